// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM control FSM: states, opcode and cmd
// fields, and the datapath select / ALU control codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] SRCA_RD1 = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] REG_PC = 4'd15;

  // States that talk to memory and may be stretched by a wait-state handshake.
  function automatic logic is_mem_access(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// Combinational ALU decoder: cmd/S bits plus ALUOp enable -> ALU operation and
// raw (ungated) flag-write request.
module ctrl_alu_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] funct,
  input  logic       alu_op,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);

  logic [3:0] cmd;
  logic       set_flags;

  assign cmd       = funct[4:1];
  assign set_flags = funct[0];

  // CMP is a subtraction, so besides N,Z it also updates C,V like ADD/SUB.
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_ADD:          alu_control = ALU_ADD;
        CMD_SUB, CMD_CMP: alu_control = ALU_SUB;
        CMD_AND:          alu_control = ALU_AND;
        CMD_ORR:          alu_control = ALU_ORR;
        default:          alu_control = ALU_ADD;
      endcase
      flag_w[1] = set_flags;
      flag_w[0] = set_flags & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle ARM datapath. Define CTRL_MEMWAIT_EN to
// stretch FETCH/MEMREAD/MEMWRITE until MemReady; otherwise MemReady is ignored.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] FlagWrite
);

  state_t     state;
  state_t     next_state;
  logic       mem_ready;
  logic       ir_w;
  logic       next_pc;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic [1:0] flag_w;
  logic       rd_is_pc;

`ifdef CTRL_MEMWAIT_EN
  assign mem_ready = MemReady | ~is_mem_access(state);
`else
  logic unused_memready;
  assign unused_memready = MemReady;
  assign mem_ready       = 1'b1;
`endif

  assign rd_is_pc = (Rd == REG_PC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:   next_state = S_MEMADR;
          OP_DP:    next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:    next_state = S_BRANCH;
          OP_UNDEF: next_state = S_FETCH;
          default:  next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // Raw per-state requests; CondEx gating and reset masking happen below.
  always_comb begin
    ir_w      = 1'b0;
    AdrSrc    = 1'b0;
    ALUOp     = 1'b0;
    ALUSrcA   = SRCA_RD1;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_w      = mem_ready;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        next_pc   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_EXTIMM;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        reg_w     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = mem_ready;
      end
      S_EXECUTER: begin
        ALUOp = 1'b1;
      end
      S_EXECUTEI: begin
        ALUOp   = 1'b1;
        ALUSrcB = SRCB_EXTIMM;
      end
      S_ALUWB: begin
        reg_w = (Funct[4:1] != CMD_CMP);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: begin
        ir_w = 1'b0;
      end
    endcase
  end

  ctrl_alu_decode u_alu_decode (
    .funct       (Funct[4:0]),
    .alu_op      (ALUOp),
    .alu_control (ALUControl),
    .flag_w      (flag_w)
  );

  // A write to R15 is a jump: it goes to the PC, never the register file.
  assign IRWrite   = reset & ir_w;
  assign RegWrite  = reset & reg_w & CondEx & ~rd_is_pc;
  assign PCWrite   = reset & (next_pc | ((branch | (reg_w & rd_is_pc)) & CondEx));
  assign MemWrite  = reset & mem_w & CondEx;
  assign FlagWrite = flag_w & {2{CondEx & reset}};

endmodule
